// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and the shift sequencer: flag indices, shift opcodes,
// and the parity helper.
package alu_pkg;

  typedef enum int unsigned {
    FlagAc = 0,
    FlagCy = 1,
    FlagV  = 2,
    FlagP  = 3,
    FlagS  = 4,
    FlagZ  = 5
  } flag_idx_e;

  localparam int unsigned NumFlags = 6;

  typedef enum logic [2:0] {
    OpRol    = 3'd0,
    OpRor    = 3'd1,
    OpRcl    = 3'd2,
    OpRcr    = 3'd3,
    OpShl    = 3'd4,
    OpShr    = 3'd5,
    OpShlAlt = 3'd6,
    OpSar    = 3'd7
  } shift_op_e;

  // Even parity: 1 when the number of set bits is even.
  function automatic logic parity_even(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One single-bit shift/rotate step on either the low half or the full datapath.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  shift_op_e         op_i,
  input  logic              size_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] value_o,
  output logic              c_o
);

  localparam int unsigned Half = DATA_W / 2;

  logic msb, lsb, left, fill;

  always_comb begin
    msb  = size_i ? value_i[DATA_W-1] : value_i[Half-1];
    lsb  = value_i[0];
    left = 1'b0;
    fill = 1'b0;
    unique case (op_i)
      OpRol:           begin left = 1'b1; fill = msb; end
      OpRcl:           begin left = 1'b1; fill = c_i; end
      OpShl, OpShlAlt: begin left = 1'b1; fill = 1'b0; end
      OpRor:           fill = lsb;
      OpRcr:           fill = c_i;
      OpShr:           fill = 1'b0;
      OpSar:           fill = msb;
      default:         fill = 1'b0;
    endcase

    value_o = value_i;
    c_o     = c_i;
    // In byte mode the upper half passes through untouched.
    if (left) begin
      c_o     = msb;
      value_o = size_i ? {value_i[DATA_W-2:0], fill}
                       : {value_i[DATA_W-1:Half], value_i[Half-2:0], fill};
    end else begin
      c_o     = lsb;
      value_o = size_i ? {fill, value_i[DATA_W-1:1]}
                       : {value_i[DATA_W-1:Half], fill, value_i[Half-1:1]};
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle group-2 shift/rotate unit: one bit per clock, flags and result
// published together with a one-cycle done pulse.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic                size,
  input  logic [DATA_W-1:0]   operand,
  input  logic [7:0]          count,
  input  logic                cy_in,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic [NumFlags-1:0] flags,
  output logic [NumFlags-1:0] flags_we
);

  localparam int unsigned Half = DATA_W / 2;

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e              state_q, state_d;
  shift_op_e           op_q, op_d;
  logic                size_q, size_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                c_q, c_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                orig_msb_q, orig_msb_d;
  logic                nz_q, nz_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [NumFlags-1:0] flags_q, flags_d;
  logic [NumFlags-1:0] we_q, we_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   step_val;
  logic                step_c;
  logic [CNT_W-1:0]    n_in;
  logic [NumFlags-1:0] fin_flags, fin_we;
  logic                res_msb, res_msb1, res_zero;
  logic                unused_count;

  assign n_in         = count[CNT_W-1:0];
  assign unused_count = ^count;

  alu_shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .op_i    (op_q),
    .size_i  (size_q),
    .value_i (val_q),
    .c_i     (c_q),
    .value_o (step_val),
    .c_o     (step_c)
  );

  always_comb begin
    res_msb   = size_q ? val_q[DATA_W-1] : val_q[Half-1];
    res_msb1  = size_q ? val_q[DATA_W-2] : val_q[Half-2];
    res_zero  = size_q ? (val_q == '0) : (val_q[Half-1:0] == '0);
    fin_flags = '0;
    fin_flags[FlagCy] = c_q;
    fin_flags[FlagP]  = parity_even(val_q[7:0]);
    fin_flags[FlagS]  = res_msb;
    fin_flags[FlagZ]  = res_zero;
    unique case (op_q)
      OpRol, OpRcl, OpShl, OpShlAlt: fin_flags[FlagV] = res_msb ^ c_q;
      OpRor, OpRcr:                  fin_flags[FlagV] = res_msb ^ res_msb1;
      OpShr:                         fin_flags[FlagV] = orig_msb_q;
      OpSar:                         fin_flags[FlagV] = 1'b0;
      default:                       fin_flags[FlagV] = 1'b0;
    endcase

    fin_we = '0;
    if (nz_q) begin
      fin_we[FlagCy] = 1'b1;
      fin_we[FlagV]  = 1'b1;
      if (!(op_q inside {OpRol, OpRor, OpRcl, OpRcr})) begin
        fin_we[FlagP] = 1'b1;
        fin_we[FlagS] = 1'b1;
        fin_we[FlagZ] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    size_d     = size_q;
    val_d      = val_q;
    c_d        = c_q;
    rem_d      = rem_q;
    orig_msb_d = orig_msb_q;
    nz_d       = nz_q;
    result_d   = result_q;
    flags_d    = flags_q;
    we_d       = we_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d       = shift_op_e'(op);
          size_d     = size;
          val_d      = operand;
          c_d        = cy_in;
          rem_d      = n_in;
          orig_msb_d = size ? operand[DATA_W-1] : operand[Half-1];
          nz_d       = (n_in != '0);
          state_d    = (n_in != '0) ? StShift : StFin;
        end
      end
      StShift: begin
        val_d = step_val;
        c_d   = step_c;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = StFin;
      end
      StFin: begin
        state_d  = StIdle;
        done_d   = 1'b1;
        result_d = val_q;
        flags_d  = fin_flags & fin_we;
        we_d     = fin_we;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpRol;
      size_q     <= 1'b0;
      val_q      <= '0;
      c_q        <= 1'b0;
      rem_q      <= '0;
      orig_msb_q <= 1'b0;
      nz_q       <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      we_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      size_q     <= size_d;
      val_q      <= val_d;
      c_q        <= c_d;
      rem_q      <= rem_d;
      orig_msb_q <= orig_msb_d;
      nz_q       <= nz_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      we_q       <= we_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign flags_we = done_q ? we_q : '0;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq: expectations queued at launch, checked at done.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        reset, start, size, cy_in;
  logic [2:0]  op;
  logic [15:0] operand;
  logic [7:0]  count;
  logic        busy, done;
  logic [15:0] result;
  logic [5:0]  flags, flags_we;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [15:0] res;
    logic [5:0]  flg;
    logic [5:0]  we;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_shift_seq #(
    .DATA_W (16),
    .CNT_W  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .size     (size),
    .operand  (operand),
    .count    (count),
    .cy_in    (cy_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flags    (flags),
    .flags_we (flags_we)
  );

  // Reference: bit-serial on an integer holding only the active width.
  function automatic exp_t model(input int o, input bit s, input logic [15:0] a,
                                 input logic [7:0] cnt, input bit ci);
    exp_t        e;
    int          w = s ? 16 : 8;
    int          n = int'(cnt & 8'h1F);
    int unsigned mask = (32'd1 << w) - 1;
    int unsigned v = a & mask;
    int unsigned nv;
    bit          c = ci;
    bit          m, l, rmsb, rmsb1, ovf;
    logic [5:0]  f = '0;
    for (int i = 0; i < n; i++) begin
      m = v[w-1];
      l = v[0];
      case (o)
        0: begin nv = ((v << 1) | m) & mask; c = m; end
        1: begin nv = (v >> 1) | (int'(l) << (w - 1)); c = l; end
        2: begin nv = ((v << 1) | c) & mask; c = m; end
        3: begin nv = (v >> 1) | (int'(c) << (w - 1)); c = l; end
        5: begin nv = v >> 1; c = l; end
        7: begin nv = (v >> 1) | (int'(m) << (w - 1)); c = l; end
        default: begin nv = (v << 1) & mask; c = m; end
      endcase
      v = nv;
    end
    e.res = (a & ~mask[15:0]) | v[15:0];
    rmsb  = v[w-1];
    rmsb1 = v[w-2];
    case (o)
      1, 3:    ovf = rmsb ^ rmsb1;
      5:       ovf = a[w-1];
      7:       ovf = 1'b0;
      default: ovf = rmsb ^ c;
    endcase
    f[1]  = c;
    f[2]  = ovf;
    f[3]  = ~^e.res[7:0];
    f[4]  = rmsb;
    f[5]  = (v == 0);
    e.we  = (n == 0) ? 6'b000000 : (o < 4) ? 6'b000110 : 6'b111110;
    e.flg = f & e.we;
    e.lat = n + 1;
    return e;
  endfunction

  task automatic launch(input logic [2:0] o, input logic s, input logic [15:0] a,
                        input logic [7:0] cnt, input logic ci);
    op = o; size = s; operand = a; count = cnt; cy_in = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    while (done !== 1'b1) begin
      if (cyc >= 64) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; size = 1'b0; operand = '0; count = '0; cy_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, result, flags, flags_we} !== '0) begin
      $display("FAIL reset_state got busy=%b done=%b result=%h flags=%b we=%b want all 0",
               busy, done, result, flags, flags_we);
      errors++;
    end
    reset = 1'b0;
  endtask

  // Directed vectors with hand-derived expectations.
  task automatic test_directed();
    logic [2:0]  t_op[4]  = '{3'd0, 3'd4, 3'd3, 3'd5};
    logic        t_sz[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] t_a[4]   = '{16'h8001, 16'hAB81, 16'h0001, 16'h1234};
    logic [7:0]  t_cnt[4] = '{8'd1, 8'd3, 8'd1, 8'h20};
    logic        t_ci[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_t        t_exp[4] = '{'{16'h0003, 6'b000110, 6'b000110, 2},
                              '{16'hAB08, 6'b000000, 6'b111110, 4},
                              '{16'h0000, 6'b000010, 6'b000110, 2},
                              '{16'h1234, 6'b000000, 6'b000000, 1}};
    exp_t e;
    int   cyc;
    bit   to;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(t_exp[i]);
      launch(t_op[i], t_sz[i], t_a[i], t_cnt[i], t_ci[i]);
      wait_done(cyc, to);
      e = exp_q.pop_front();
      vectors++;
      if (to || cyc != e.lat) begin
        $display("FAIL directed%0d latency got %0d (timeout=%0b) want %0d", i, cyc, to, e.lat);
        errors++;
      end
      vectors++;
      if (result !== e.res || flags !== e.flg || flags_we !== e.we) begin
        $display("FAIL directed%0d got res=%h flags=%b we=%b want res=%h flags=%b we=%b",
                 i, result, flags, flags_we, e.res, e.flg, e.we);
        errors++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sar_ignore();
    exp_t e;
    int   cyc = 0;
    int   extra = 0;
    bit   to = 1'b0;
    exp_q.push_back('{16'hFFFF, 6'b011000, 6'b111110, 16});
    launch(3'd7, 1'b1, 16'h8000, 8'd15, 1'b1);
    while (done !== 1'b1) begin
      if (cyc >= 64) begin
        to = 1'b1;
        break;
      end
      if (cyc == 5) begin
        vectors++;
        if (busy !== 1'b1) begin
          $display("FAIL sar_busy got %b want 1", busy);
          errors++;
        end
        op = 3'd0; operand = 16'h0F0F; count = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (to || cyc != e.lat) begin
      $display("FAIL sar_latency got %0d (timeout=%0b) want %0d", cyc, to, e.lat);
      errors++;
    end
    vectors++;
    if (result !== e.res || flags !== e.flg || flags_we !== e.we) begin
      $display("FAIL sar_result got res=%h flags=%b we=%b want res=%h flags=%b we=%b",
               result, flags, flags_we, e.res, e.flg, e.we);
      errors++;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      $display("FAIL sar_no_queue got %0d extra done pulses want 0", extra);
      errors++;
    end
    vectors++;
    if (result !== 16'hFFFF) begin
      $display("FAIL sar_hold got res=%h want ffff", result);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    int   seen = 0;
    bit   to;
    launch(3'd4, 1'b1, 16'h5A5A, 8'd20, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || result !== 16'h0000 || done !== 1'b0) begin
      $display("FAIL reset_mid got busy=%b res=%h done=%b want 0 0000 0", busy, result, done);
      errors++;
    end
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1 if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      $display("FAIL reset_mid_done got %0d done pulses want 0", seen);
      errors++;
    end
    exp_q.push_back('{16'h0003, 6'b000110, 6'b000110, 2});
    launch(3'd0, 1'b1, 16'h8001, 8'd1, 1'b0);
    wait_done(cyc, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || cyc != e.lat || result !== e.res || flags !== e.flg || flags_we !== e.we) begin
      $display("FAIL after_reset got lat=%0d res=%h flags=%b we=%b want lat=%0d res=%h flags=%b we=%b",
               cyc, result, flags, flags_we, e.lat, e.res, e.flg, e.we);
      errors++;
    end
  endtask

  // Each new op is requested in the done cycle of the previous one.
  task automatic test_back_to_back(input int num, input string name);
    exp_t        e;
    int          cyc;
    bit          to;
    logic [15:0] r;
    logic [5:0]  f, w;
    logic [2:0]  o  = 3'($urandom_range(0, 7));
    logic        s  = 1'($urandom);
    logic [15:0] a  = 16'($urandom);
    logic [7:0]  cn = 8'($urandom_range(0, 40));
    logic        ci = 1'($urandom);
    exp_q.push_back(model(int'(o), s, a, cn, ci));
    launch(o, s, a, cn, ci);
    for (int i = 0; i < num; i++) begin
      wait_done(cyc, to);
      r = result; f = flags; w = flags_we;
      if (i < num - 1) begin
        o = 3'($urandom_range(0, 7)); s = 1'($urandom); a = 16'($urandom);
        cn = 8'($urandom); ci = 1'($urandom);
        exp_q.push_back(model(int'(o), s, a, cn, ci));
        launch(o, s, a, cn, ci);
      end
      e = exp_q.pop_front();
      vectors++;
      if (to || cyc != e.lat || r !== e.res || f !== e.flg || w !== e.we) begin
        $display("FAIL %s%0d got lat=%0d res=%h flags=%b we=%b want lat=%0d res=%h flags=%b we=%b",
                 name, i, cyc, r, f, w, e.lat, e.res, e.flg, e.we);
        errors++;
        if (to) break;
      end
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sar_ignore();
    test_reset_mid();
    @(posedge clk);
    #1;
    test_back_to_back(6, "b2b");
    test_back_to_back(30, "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Multi-cycle shift/rotate unit for the execute stage; takes the group-2 ops (ROL, ROR, RCL, RCR, SHL, SHR, SAR) off the combinational ALU path.
- Shifts one bit per clock, so latency tracks the masked count, as on the V30MZ.
- Parametrised in datapath width and count mask. Adds rotate-through-carry, arithmetic right shift and per-flag write enables.

Parameters:
- DATA_W, 16, datapath width; even, >= 8.
- CNT_W, 5, count bits kept after masking; count is reduced to count[CNT_W-1:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SHL (alias), 7 SAR
- size  in  1  0: low half (DATA_W/2 bits); 1: full DATA_W
- operand  in  DATA_W  value to shift
- count  in  8  shift count, masked to CNT_W bits
- cy_in  in  1  current carry flag; used by RCL/RCR
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; result/flags valid
- result  out  DATA_W  shifted value, held until next accept
- flags  out  6  flag vector in the shared flag-index order: AC=0, CY=1, V=2, P=3, S=4, Z=5
- flags_we  out  6  per-flag write enable, qualified by done

Behaviour:
- Reset: state IDLE; busy, done, result, flags, flags_we all 0. Applies mid-operation: the in-flight op is dropped, no done pulse, next start accepted the cycle after reset deasserts.
- FSM states: IDLE, SHIFT, FIN.
- IDLE + start: latch op, size, operand, cy_in and n = count[CNT_W-1:0].
  - n != 0: go to SHIFT with remaining = n.
  - n == 0: go to FIN with flags_we = 0 and result = operand.
- SHIFT: one single-bit step per cycle; remaining decrements. The step with remaining == 1 moves to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. start is accepted again in that same cycle after FIN, so back-to-back ops lose no cycle.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0+n+1 (n>0), or after edge E0+1 (n=0).
- busy=1 in SHIFT and FIN. start while busy is ignored and not queued.
- Byte mode (size=0):
  - Only bits [DATA_W/2-1:0] shift.
  - Upper half of result equals operand upper half.
  - msb means bit DATA_W/2-1.
- Step rules (c = internal carry, seeded with cy_in):
  - ROL: lsb <- msb, c <- old msb.
  - ROR: msb <- lsb, c <- old lsb.
  - RCL: lsb <- c, c <- old msb.
  - RCR: msb <- c, c <- old lsb.
  - SHL: lsb <- 0, c <- old msb.
  - SHR: msb <- 0, c <- old lsb.
  - SAR: msb kept, c <- old lsb.
- Final flags:
  - CY = c.
  - V, left ops (ROL/RCL/SHL): msb(result) ^ CY.
  - V, ROR/RCR: msb ^ (msb-1) of result.
  - V, SHR: msb of original operand.
  - V, SAR: 0.
  - Z: active-width result == 0.
  - S: msb of result.
  - P: even parity of result[7:0], 1 when the count of ones is even.
- flags_we: rotates CY,V; shifts CY,V,P,S,Z; AC never written. Flags not written read as 0.

Decomposition:
- Shared package alu_pkg holds:
  - Flag index enum (AC, CY, V, P, S, Z), moved out of the ALU file so both blocks share it.
  - Shift op encoding enum (values 0..7 above).
  - Parity function.
- One sub-module, alu_shift_step: combinational single-bit step (op, size, value, c) -> (value', c'). Instantiated once and reused every cycle.

Test Plan:
- ROL, size=1, operand 0x8001, count 1 -> result 0x0003, CY=1, V=1, flags_we CY|V only, done in cycle after E0+2.
- SHL, size=0, operand 0xAB81, count 3 -> result 0xAB08, CY=0, V=0, Z=0, S=0, P=0, done after E0+4.
- RCR, size=1, operand 0x0001, cy_in=0, count 1 -> result 0x0000, CY=1, V=0, Z not written (flags_we[Z]=0).
- Any op, count 0x20 (masks to 0), operand 0x1234 -> done after E0+1, result 0x1234, flags_we=0.
- SAR, size=1, operand 0x8000, count 15 -> result 0xFFFF, CY=0, V=0, S=1, Z=0, P=1, done after E0+16; start pulsed mid-op is ignored.
- SHL count 20 started, reset asserted 5 cycles later -> busy=0 and result=0 next cycle, no done pulse; new ROL count 1 started after reset completes normally.
